// File: rtl/md5_pkg.sv
// Shared constants, state encoding and per-byte source selection for the MD5 padder.
// Pure declarations: no logic, no latency, no flow control.
package md5_pkg;

  localparam int         MD5_BLOCK_BYTES = 64;
  localparam int         MD5_LEN_BYTES   = 8;
  localparam logic [7:0] MD5_PAD_BYTE    = 8'h80;
  localparam int         MD5_LEN_START   = MD5_BLOCK_BYTES - MD5_LEN_BYTES;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_EMIT,
    ST_EXTRA
  } md5_state_t;

  typedef enum logic [1:0] {
    SRC_DATA,
    SRC_PAD,
    SRC_ZERO,
    SRC_LEN
  } md5_src_t;

  // fill: bytes of message data in the block; term: message ends in this block;
  // extra: the overflow block that carries only padding and length.
  function automatic md5_src_t byte_src(input int k, input logic [6:0] fill,
                                        input logic term, input logic extra,
                                        input logic pad0);
    md5_src_t src;
    src = SRC_ZERO;
    if (extra) begin
      if (k >= MD5_LEN_START)     src = SRC_LEN;
      else if (k == 0 && pad0)    src = SRC_PAD;
    end else if (k < int'(fill)) begin
      src = SRC_DATA;
    end else if (term && k == int'(fill)) begin
      src = SRC_PAD;
    end else if (term && k >= MD5_LEN_START && int'(fill) < MD5_LEN_START) begin
      src = SRC_LEN;
    end
    return src;
  endfunction

endpackage

// File: rtl/md5_pad_sel.sv
// Combinational block former: picks data, 0x80, zero or length for each of the 64 bytes.
// Zero latency; no flow control of its own.
module md5_pad_sel
  import md5_pkg::*;
#(
  parameter int LEN_W = 61
) (
  input  logic [8*MD5_BLOCK_BYTES-1:0] data_blk,
  input  logic [6:0]                   fill,
  input  logic                         term,
  input  logic                         extra,
  input  logic                         pad0,
  input  logic [LEN_W-1:0]             msg_len,
  output logic [8*MD5_BLOCK_BYTES-1:0] blk
);

  logic [63:0] bit_len;

  always_comb begin
    bit_len = 64'(msg_len) << 3;
    blk     = '0;
    for (int k = 0; k < MD5_BLOCK_BYTES; k++) begin
      case (byte_src(k, fill, term, extra, pad0))
        SRC_DATA: blk[k*8 +: 8] = data_blk[k*8 +: 8];
        SRC_PAD:  blk[k*8 +: 8] = MD5_PAD_BYTE;
        // length field starts on an 8-byte boundary, so k%8 is the length byte index
        SRC_LEN:  blk[k*8 +: 8] = bit_len[(k % 8)*8 +: 8];
        default:  blk[k*8 +: 8] = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/md5_padder.sv
// Packs message beats into 64-byte blocks with MD5 padding; block valid the cycle after the
// completing beat, held stable until out_ready; in_ready is low whenever a block is held.
module md5_padder
  import md5_pkg::*;
#(
  parameter int IN_BYTES = 4,
  parameter int LEN_W    = 61
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [8*IN_BYTES-1:0]         in_data,
  input  logic [$clog2(IN_BYTES+1)-1:0] in_nbytes,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [8*MD5_BLOCK_BYTES-1:0]  out_block,
  output logic                          out_last,
  output logic                          busy
);

  localparam int NB_W  = $clog2(IN_BYTES + 1);
  localparam int SLOTS = MD5_BLOCK_BYTES / IN_BYTES;

  md5_state_t                   state_q;
  logic [6:0]                   fill_q;
  logic [LEN_W-1:0]             cnt_q;
  logic [8*MD5_BLOCK_BYTES-1:0] buf_q;
  logic                         pending_q;
  logic                         pad0_q;

  logic [6:0]                   n_eff;
  logic [6:0]                   fill_nxt;
  logic [LEN_W-1:0]             cnt_nxt;
  logic [8*MD5_BLOCK_BYTES-1:0] merged;
  logic [8*MD5_BLOCK_BYTES-1:0] sel_blk;
  logic [LEN_W-1:0]             sel_len;
  logic                         sel_extra;
  logic                         blk_done;

  assign in_ready  = rst_n && (state_q == ST_FILL);
  assign out_valid = (state_q != ST_FILL);
  assign busy      = (state_q != ST_FILL) || (cnt_q != '0);

  always_comb begin
    n_eff = 7'(IN_BYTES);
    if (in_last && (in_nbytes < NB_W'(IN_BYTES))) n_eff = 7'(in_nbytes);
  end

  assign fill_nxt = fill_q + n_eff;
  assign cnt_nxt  = cnt_q + LEN_W'(n_eff);
  assign blk_done = in_last || (fill_nxt == 7'(MD5_BLOCK_BYTES));

  // Non-last beats are always full, so the fill offset is a whole number of beat slots.
  always_comb begin
    merged = buf_q;
    for (int s = 0; s < SLOTS; s++) begin
      if (fill_q == 7'(s*IN_BYTES)) begin
        for (int i = 0; i < IN_BYTES; i++) begin
          if (7'(i) < n_eff) merged[(s*IN_BYTES + i)*8 +: 8] = in_data[i*8 +: 8];
        end
      end
    end
  end

  // In EMIT the former is only consulted to build the overflow block.
  assign sel_extra = (state_q == ST_EMIT);
  assign sel_len   = sel_extra ? cnt_q : cnt_nxt;

  md5_pad_sel #(
    .LEN_W(LEN_W)
  ) u_pad_sel (
    .data_blk(merged),
    .fill    (fill_nxt),
    .term    (in_last),
    .extra   (sel_extra),
    .pad0    (pad0_q),
    .msg_len (sel_len),
    .blk     (sel_blk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      fill_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      pending_q <= 1'b0;
      pad0_q    <= 1'b0;
      out_block <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (in_valid) begin
            cnt_q <= cnt_nxt;
            if (blk_done) begin
              out_block <= sel_blk;
              out_last  <= in_last && (fill_nxt < 7'(MD5_LEN_START));
              pending_q <= in_last && (fill_nxt >= 7'(MD5_LEN_START));
              pad0_q    <= (fill_nxt == 7'(MD5_BLOCK_BYTES));
              fill_q    <= '0;
              state_q   <= ST_EMIT;
            end else begin
              buf_q  <= merged;
              fill_q <= fill_nxt;
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (pending_q) begin
              out_block <= sel_blk;
              out_last  <= 1'b1;
              pending_q <= 1'b0;
              state_q   <= ST_EXTRA;
            end else begin
              if (out_last) cnt_q <= '0;
              out_last <= 1'b0;
              state_q  <= ST_FILL;
            end
          end
        end
        ST_EXTRA: begin
          if (out_ready) begin
            cnt_q    <= '0;
            out_last <= 1'b0;
            state_q  <= ST_FILL;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_padder.sv
// Drives three padder instances (4, 8 and 64 bytes per beat) with directed and random messages
// and compares every block against a byte-stream MD5 padding model.
module tb_md5_padder;

  typedef byte unsigned bq_t[$];

  logic         clk;
  logic         rst_n;
  int           sel;
  logic         drv_valid, drv_last, drv_ready;
  logic [511:0] drv_data;
  logic [6:0]   drv_nbytes;
  logic [2:0]   iv_w, or_w;

  logic         ir4, ov4, ol4, bz4;
  logic         ir8, ov8, ol8, bz8;
  logic         ir64, ov64, ol64, bz64;
  logic [511:0] ob4, ob8, ob64;

  logic         obs_ready, obs_valid, obs_last, obs_busy;
  logic [511:0] obs_block;

  int vectors     = 0;
  int miscompares = 0;

  logic [511:0] exp_blk[$];
  bit           exp_last[$];
  logic [511:0] obs_blk[$];
  bit           obs_lst[$];

  assign iv_w = drv_valid ? 3'(1 << sel) : 3'b000;
  assign or_w = drv_ready ? 3'(1 << sel) : 3'b000;

  md5_padder #(.IN_BYTES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_w[0]), .in_ready(ir4),
    .in_data(drv_data[31:0]), .in_nbytes(drv_nbytes[2:0]), .in_last(drv_last),
    .out_valid(ov4), .out_ready(or_w[0]), .out_block(ob4), .out_last(ol4), .busy(bz4)
  );

  md5_padder #(.IN_BYTES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_w[1]), .in_ready(ir8),
    .in_data(drv_data[63:0]), .in_nbytes(drv_nbytes[3:0]), .in_last(drv_last),
    .out_valid(ov8), .out_ready(or_w[1]), .out_block(ob8), .out_last(ol8), .busy(bz8)
  );

  md5_padder #(.IN_BYTES(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_w[2]), .in_ready(ir64),
    .in_data(drv_data), .in_nbytes(drv_nbytes), .in_last(drv_last),
    .out_valid(ov64), .out_ready(or_w[2]), .out_block(ob64), .out_last(ol64), .busy(bz64)
  );

  always_comb begin
    obs_ready = ir4; obs_valid = ov4; obs_last = ol4; obs_busy = bz4; obs_block = ob4;
    case (sel)
      1: begin obs_ready = ir8;  obs_valid = ov8;  obs_last = ol8;  obs_busy = bz8;  obs_block = ob8;  end
      2: begin obs_ready = ir64; obs_valid = ov64; obs_last = ol64; obs_busy = bz64; obs_block = ob64; end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic int ib_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 8 : 64;
  endfunction

  function automatic int maxn_of(input int d);
    return (d == 0) ? 7 : (d == 1) ? 15 : 127;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: message, 0x80, zeros up to 56 mod 64, 64-bit little-endian bit length.
  function automatic void build_ref(input bq_t msg);
    bq_t          s;
    logic [63:0]  bitlen;
    logic [511:0] blk;
    int           nblk;
    exp_blk.delete();
    exp_last.delete();
    s = msg;
    s.push_back(8'h80);
    while (s.size() % 64 != 56) s.push_back(8'h00);
    bitlen = 64'(msg.size()) * 64'd8;
    for (int i = 0; i < 8; i++) s.push_back(bitlen[i*8 +: 8]);
    nblk = s.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < 64; k++) blk[k*8 +: 8] = s[b*64 + k];
      exp_blk.push_back(blk);
      exp_last.push_back(b == nblk - 1);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge of the final block transfer.
  task automatic run_msg(input int d, input bq_t msg, input int idle_pct, input int stall_pct,
                         input int hold);
    logic [511:0] bd[$];
    int           bn[$];
    int           bc[$];
    bit           bl[$];
    logic [511:0] w, prev_blk;
    logic         prev_last;
    int           ib, maxn, nfull, rem, cnt, pos, bi, ki, cyc, acc, hold_left;
    bit           prev_stall, expect_ov;

    ib   = ib_of(d);
    maxn = maxn_of(d);
    sel  = d;
    build_ref(msg);
    obs_blk.delete();
    obs_lst.delete();

    nfull = msg.size() / ib;
    rem   = msg.size() % ib;
    if (rem == 0 && nfull > 0 && $urandom_range(1) == 1) begin
      nfull--;
      rem = ib;
    end
    pos = 0;
    for (int b = 0; b <= nfull; b++) begin
      w   = rand512();
      cnt = (b == nfull) ? rem : ib;
      for (int i = 0; i < cnt; i++) w[i*8 +: 8] = msg[pos + i];
      pos += cnt;
      bd.push_back(w);
      bc.push_back(cnt);
      bl.push_back(b == nfull);
      if (b < nfull)                                 bn.push_back(int'($urandom_range(maxn)));
      else if (rem == ib && $urandom_range(1) == 1)  bn.push_back(int'($urandom_range(maxn, ib + 1)));
      else                                           bn.push_back(rem);
    end

    bi = 0; ki = 0; cyc = 0; acc = 0; hold_left = hold;
    prev_stall = 1'b0; expect_ov = 1'b0; prev_blk = '0; prev_last = 1'b0;
    while (ki < int'(exp_blk.size()) && cyc < 3000) begin
      if (bi < int'(bd.size()) && int'($urandom_range(99)) >= idle_pct) begin
        drv_valid  = 1'b1;
        drv_data   = bd[bi];
        drv_nbytes = 7'(bn[bi]);
        drv_last   = bl[bi];
      end else begin
        drv_valid  = 1'b0;
        drv_data   = rand512();
        drv_nbytes = 7'($urandom_range(maxn));
        drv_last   = 1'($urandom_range(1));
      end
      drv_ready = (hold_left > 0) ? 1'b0 : (int'($urandom_range(99)) >= stall_pct);

      @(negedge clk);
      check("ready_is_not_valid", 512'(obs_ready), 512'(!obs_valid));
      if (expect_ov) check("valid_one_cycle_after_beat", 512'(obs_valid), 512'(1));
      expect_ov = 1'b0;
      if (prev_stall) begin
        check("stalled_block_stable", obs_block, prev_blk);
        check("stalled_last_stable", 512'(obs_last), 512'(prev_last));
      end
      if (obs_valid && hold_left > 0) hold_left--;
      prev_stall = obs_valid && !drv_ready;
      prev_blk   = obs_block;
      prev_last  = obs_last;
      if (obs_valid && drv_ready) begin
        obs_blk.push_back(obs_block);
        obs_lst.push_back(obs_last);
        check("block_data", obs_block, exp_blk[ki]);
        check("block_last", 512'(obs_last), 512'(exp_last[ki]));
        ki++;
      end
      if (drv_valid && obs_ready) begin
        acc += bc[bi];
        expect_ov = bl[bi] || (acc % 64 == 0);
        bi++;
      end
      tick();
      cyc++;
    end
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    check("all_beats_taken", 512'(bi), 512'(bd.size()));
    check("all_blocks_seen", 512'(ki), 512'(exp_blk.size()));
    check("idle_out_valid", 512'(obs_valid), 512'(0));
    check("idle_busy", 512'(obs_busy), 512'(0));
  endtask

  initial begin : stim
    bq_t          msg;
    logic [511:0] e;
    int           bound_lens[9];
    int           d, len;

    bound_lens = '{0, 55, 56, 57, 63, 64, 65, 119, 128};
    rst_n      = 1'b0;
    sel        = 0;
    drv_valid  = 1'b0;
    drv_last   = 1'b0;
    drv_ready  = 1'b0;
    drv_data   = '0;
    drv_nbytes = '0;

    // Reset state on every instance
    #2;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check("rst_out_valid", 512'(obs_valid), 512'(0));
      check("rst_in_ready", 512'(obs_ready), 512'(0));
      check("rst_busy", 512'(obs_busy), 512'(0));
      check("rst_out_last", 512'(obs_last), 512'(0));
      check("rst_out_block", obs_block, '0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // "abc" in one beat of 4 bytes
    msg = {};
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(0, msg, 0, 0, 0);
    e = '0; e[31:0] = 32'h80636261; e[455:448] = 8'h18;
    check("abc_count", 512'(obs_blk.size()), 512'(1));
    check("abc_block", obs_blk[0], e);
    check("abc_last", 512'(obs_lst[0]), 512'(1));

    // Empty message
    msg = {};
    run_msg(0, msg, 0, 0, 0);
    e = '0; e[7:0] = 8'h80;
    check("empty_count", 512'(obs_blk.size()), 512'(1));
    check("empty_block", obs_blk[0], e);
    check("empty_last", 512'(obs_lst[0]), 512'(1));

    // 56 bytes on the 8-byte instance: padding spills into a second block
    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(8'($urandom));
    run_msg(1, msg, 0, 0, 0);
    e = '0; e[455:448] = 8'hC0; e[463:456] = 8'h01;
    check("m56_count", 512'(obs_blk.size()), 512'(2));
    e[511:448] = 64'h80;
    w_check56: begin
      logic [511:0] b0;
      b0 = obs_blk[0];
      check("m56_b0_tail", 512'(b0[511:448]), 512'(64'h80));
    end
    check("m56_b0_last", 512'(obs_lst[0]), 512'(0));
    e = '0; e[455:448] = 8'hC0; e[463:456] = 8'h01;
    check("m56_b1_block", obs_blk[1], e);
    check("m56_b1_last", 512'(obs_lst[1]), 512'(1));

    // 64 bytes on the 64-byte instance
    msg = {};
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    run_msg(2, msg, 0, 0, 0);
    for (int k = 0; k < 64; k++) e[k*8 +: 8] = msg[k];
    check("m64_count", 512'(obs_blk.size()), 512'(2));
    check("m64_b0_data", obs_blk[0], e);
    check("m64_b0_last", 512'(obs_lst[0]), 512'(0));
    e = '0; e[7:0] = 8'h80; e[463:456] = 8'h02;
    check("m64_b1_block", obs_blk[1], e);
    check("m64_b1_last", 512'(obs_lst[1]), 512'(1));

    // Consumer holds out_ready low for 10 cycles
    msg = {};
    for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
    run_msg(0, msg, 0, 0, 10);

    // Reset in the middle of a message
    sel        = 0;
    drv_valid  = 1'b1;
    drv_last   = 1'b0;
    drv_nbytes = '0;
    drv_data   = rand512();
    @(negedge clk);
    check("mid_beat_ready", 512'(obs_ready), 512'(1));
    tick();
    drv_valid = 1'b0;
    check("mid_busy", 512'(obs_busy), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 512'(obs_valid), 512'(0));
    check("mid_rst_ready", 512'(obs_ready), 512'(0));
    check("mid_rst_busy", 512'(obs_busy), 512'(0));
    tick();
    rst_n = 1'b1;

    // Reset while a block waits for the consumer
    drv_valid  = 1'b1;
    drv_last   = 1'b1;
    drv_nbytes = 7'd2;
    drv_data   = rand512();
    tick();
    drv_valid = 1'b0;
    check("pend_valid", 512'(obs_valid), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    check("pend_rst_valid", 512'(obs_valid), 512'(0));
    check("pend_rst_block", obs_block, '0);
    check("pend_rst_last", 512'(obs_last), 512'(0));
    tick();
    rst_n = 1'b1;
    drv_ready = 1'b1;
    tick();
    tick();
    check("no_stale_block", 512'(obs_valid), 512'(0));
    drv_ready = 1'b0;

    // Length restarts from zero after reset
    msg = {};
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(0, msg, 0, 0, 0);
    e = '0; e[31:0] = 32'h80636261; e[455:448] = 8'h18;
    check("post_rst_abc", obs_blk[0], e);

    // Random messages, boundary-biased lengths, random gaps and stalls
    for (int t = 0; t < 30; t++) begin
      d   = int'($urandom_range(2));
      len = ($urandom_range(1) == 1) ? bound_lens[$urandom_range(8)] : int'($urandom_range(200));
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      run_msg(d, msg, int'($urandom_range(40)), int'($urandom_range(40)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
